// File: rtl/mul_arb_pkg.sv
// Shared types and sizing helpers for the shared shift-add multiplier controller.
package mul_arb_pkg;

   localparam int DEF_NREQ = 4;
   localparam int DEF_W    = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } mul_state_e;

   function automatic int idw_of(input int nreq);
      return (nreq > 1) ? $clog2(nreq) : 1;
   endfunction

endpackage

// File: rtl/mul_arb_ctrl_if.sv
// Request/response bundle between the DSP front-ends and the shared multiplier.
interface mul_arb_ctrl_if
   import mul_arb_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int W    = DEF_W,
   parameter int IDW  = idw_of(NREQ)
);

   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_m;
   logic [NREQ*W-1:0] req_q;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [2*W-1:0]    rsp_product;
   logic [IDW-1:0]    rsp_id;

   modport master (
      output req_valid, req_m, req_q, rsp_ready,
      input  req_ready, rsp_valid, rsp_product, rsp_id
   );

   modport slave (
      input  req_valid, req_m, req_q, rsp_ready,
      output req_ready, rsp_valid, rsp_product, rsp_id
   );

endinterface

// File: rtl/mul_arb_ctrl_core.sv
// Sequential W-step shift-add multiplier; product holds after the last step.
module shift_add_mul_core
   import mul_arb_pkg::*;
#(
   parameter int W = DEF_W
)
(
   input  logic           clk,
   input  logic           n_rst,
   input  logic           start,
   input  logic [W-1:0]   m,
   input  logic [W-1:0]   q,
   output logic           busy,
   output logic           done_pulse,
   output logic [2*W-1:0] product
);

   localparam int            CW    = $clog2(W + 1);
   localparam logic [CW-1:0] STEPS = CW'(W);
   localparam logic [CW-1:0] LAST  = CW'(1);

   logic [W-1:0]  m_reg;
   logic [W-1:0]  a_reg;
   logic [W-1:0]  q_reg;
   logic [CW-1:0] step_cnt;
   logic [W:0]    sum;

   assign busy       = (step_cnt != '0);
   assign done_pulse = busy && (step_cnt == LAST);
   assign product    = {a_reg, q_reg};

   // Carry lives in sum[W] and is shifted straight into A's MSB, so it never needs its own flop.
   assign sum = {1'b0, a_reg} + (q_reg[0] ? {1'b0, m_reg} : {(W+1){1'b0}});

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         m_reg    <= '0;
         a_reg    <= '0;
         q_reg    <= '0;
         step_cnt <= '0;
      end else if (start) begin
         m_reg    <= m;
         a_reg    <= '0;
         q_reg    <= q;
         step_cnt <= STEPS;
      end else if (busy) begin
         a_reg    <= sum[W:1];
         q_reg    <= {sum[0], q_reg[W-1:1]};
         step_cnt <= step_cnt - LAST;
      end
   end

endmodule

// File: rtl/mul_arb_ctrl.sv
// Arbitrates NREQ requesters onto one shift-add multiplier and returns tagged products.
// Define MUL_ARB_RR_EN for round-robin arbitration; default is fixed priority (lowest index).
//
//   state | meaning
//   IDLE  | waiting for a request; req_ready asserted combinationally for the grant
//   RUN   | core iterating W shift-add steps
//   DONE  | product valid, held until rsp_ready
module mul_arb_ctrl
   import mul_arb_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int W    = DEF_W,
   parameter int IDW  = idw_of(NREQ)
)
(
   input  logic         clk,
   input  logic         n_rst,
   mul_arb_ctrl_if.slave bus
);

   localparam logic [1:0] S_IDLE = ST_IDLE;
   localparam logic [1:0] S_RUN  = ST_RUN;
   localparam logic [1:0] S_DONE = ST_DONE;

   logic [1:0]      state;
   logic [IDW-1:0]  grant_idx;
   logic            grant_any;
   logic [IDW-1:0]  tag_reg;
   logic            start;
   logic            busy;
   logic            done_pulse;
   logic [W-1:0]    sel_m;
   logic [W-1:0]    sel_q;
   logic [NREQ-1:0] ready_vec;
   logic [2*W-1:0]  core_product;

`ifdef MUL_ARB_RR_EN
   logic [IDW-1:0] rr_ptr;

   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!grant_any && bus.req_valid[(int'(rr_ptr) + k) % NREQ]) begin
            grant_any = 1'b1;
            grant_idx = IDW'((int'(rr_ptr) + k) % NREQ);
         end
      end
   end

   // Reset pointer at the last index so requester 0 wins the first search.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         rr_ptr <= IDW'(NREQ - 1);
      else if (start)
         rr_ptr <= grant_idx;
   end
`else
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (bus.req_valid[i]) begin
            grant_any = 1'b1;
            grant_idx = IDW'(i);
         end
      end
   end
`endif

   assign start = (state == S_IDLE) && grant_any && !busy;
   assign sel_m = bus.req_m[int'(grant_idx)*W +: W];
   assign sel_q = bus.req_q[int'(grant_idx)*W +: W];

   always_comb begin
      ready_vec = '0;
      if (start)
         ready_vec[grant_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state   <= S_IDLE;
         tag_reg <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state   <= S_RUN;
                  tag_reg <= grant_idx;
               end
            end
            S_RUN: begin
               if (done_pulse)
                  state <= S_DONE;
            end
            S_DONE: begin
               if (bus.rsp_ready)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   shift_add_mul_core #(.W(W)) u_core (
      .clk        (clk),
      .n_rst      (n_rst),
      .start      (start),
      .m          (sel_m),
      .q          (sel_q),
      .busy       (busy),
      .done_pulse (done_pulse),
      .product    (core_product)
   );

   assign bus.req_ready   = ready_vec;
   assign bus.rsp_valid   = (state == S_DONE);
   assign bus.rsp_product = core_product;
   assign bus.rsp_id      = tag_reg;

endmodule
